// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam int          ADDR_W_DEF     = 32;
  localparam int          DATA_W_DEF     = 32;
  localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_1000;
  localparam int          PC_INC_DEF     = 4;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with flush; pop on empty is ignored.
module sync_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  // A full FIFO still accepts a push when the head leaves the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// PC, boot/run/halt FSM and fetch FIFO ahead of decode.
// FETCH_PERF_EN adds saturating fetch/flush counters.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int                ADDR_W     = ADDR_W_DEF,
  parameter  int                DATA_W     = DATA_W_DEF,
  parameter  int                DEPTH      = 4,
  parameter  logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DEF),
  parameter  int                PC_INC     = PC_INC_DEF,
  localparam int                CW         = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pcSelector,
  input  logic [ADDR_W-1:0] startAddress,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] currentAddress,
  input  logic [DATA_W-1:0] instruction,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              deq_ready,
  output logic [CW-1:0]     occupancy,
  output logic              halted,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              push, pop, flush, full, empty;
  entry_t            wr_e, rd_e;

  assign wr_e           = '{pc: pc_q, inst: instruction};
  assign currentAddress = pc_q;
  assign inst_valid     = !empty;
  assign inst_pc        = rd_e.pc;
  assign inst_out       = rd_e.inst;
  assign halted         = (state_q == HALT);
  assign pop            = inst_valid && deq_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (pcSelector) begin
      state_d = BOOT;
      pc_d    = startAddress;
      flush   = 1'b1;
    end else if (redirect_valid && state_q != BOOT) begin
      state_d = halt_req ? HALT : RUN;
      pc_d    = redirect_addr;
      flush   = 1'b1;
    end else begin
      unique case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (halt_req) begin
            state_d = HALT;
          end else if (!full || pop) begin
            push = 1'b1;
            pc_d = pc_q + ADDR_W'(PC_INC);
          end
        end
        HALT: state_d = HALT;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (wr_e),
    .rdata_o (rd_e),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occupancy)
  );

`ifdef FETCH_PERF_EN
  logic [31:0]   fet_q, fet_d, fls_q, fls_d;
  logic [32:0]   fls_sum;
  logic [CW-1:0] discard;

  // Entries taken by decode in the flush cycle are not counted as lost.
  assign discard = occupancy - CW'(pop);

  always_comb begin
    fet_d   = fet_q;
    fls_d   = fls_q;
    fls_sum = {1'b0, fls_q} + 33'(discard);
    if (push && fet_q != '1) fet_d = fet_q + 32'd1;
    if (flush) fls_d = fls_sum[32] ? '1 : fls_sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fet_q <= '0;
      fls_q <= '0;
    end else begin
      fet_q <= fet_d;
      fls_q <= fls_d;
    end
  end

  assign perf_fetched = fet_q;
  assign perf_flushed = fls_q;
`else
  assign perf_fetched = '0;
  assign perf_flushed = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue against a queue-based fetch model.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RADDR = 32'h0000_1000;

  typedef struct {
    logic [31:0] cur;
    logic        valid;
    logic [31:0] hpc;
    logic [31:0] hinst;
    int          occ;
    logic        halted;
    logic        zero_head;
    logic [31:0] pf;
    logic [31:0] pfl;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 0;
  logic        reset, pcSelector, redirect_valid, halt_req, deq_ready;
  logic [31:0] startAddress, redirect_addr, currentAddress, instruction;
  logic        inst_valid, halted;
  logic [31:0] inst_out, inst_pc, perf_fetched, perf_flushed;
  logic [2:0]  occupancy;

  int n_vec = 0;
  int n_err = 0;

  exp_t sb[$];

  // model state
  ent_t        mq[$];
  logic [31:0] m_pc;
  int          m_st;
  logic        m_fresh;
  longint      m_pf, m_pfl;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign instruction = imem(currentAddress);

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .pcSelector     (pcSelector),
    .startAddress   (startAddress),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halt_req       (halt_req),
    .currentAddress (currentAddress),
    .instruction    (instruction),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .deq_ready      (deq_ready),
    .occupancy      (occupancy),
    .halted         (halted),
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
  );

  function automatic longint sat(input longint v);
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc    = RADDR;
    m_st    = 0;
    m_fresh = 1'b1;
    m_pf    = 0;
    m_pfl   = 0;
  endtask

  // 0=BOOT 1=RUN 2=HALT
  task automatic model_step(input logic r, ps, rv, hr, dr,
                            input logic [31:0] sa, ra);
    if (r) begin
      model_reset();
      return;
    end
    if (mq.size() > 0 && dr) void'(mq.pop_front());
    if (ps) begin
      m_pfl = sat(m_pfl + mq.size());
      mq.delete();
      m_pc = sa;
      m_st = 0;
    end else if (rv && m_st != 0) begin
      m_pfl = sat(m_pfl + mq.size());
      mq.delete();
      m_pc = ra;
      m_st = hr ? 2 : 1;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (hr) m_st = 2;
      else if (mq.size() < DEPTH) begin
        mq.push_back('{pc: m_pc, inst: imem(m_pc)});
        m_pc    = m_pc + 32'd4;
        m_fresh = 1'b0;
        m_pf    = sat(m_pf + 1);
      end
    end
  endtask

  task automatic step(input logic r, ps, rv, hr, dr,
                      input logic [31:0] sa, ra);
    exp_t e;
    @(negedge clk);
    reset          = r;
    pcSelector     = ps;
    redirect_valid = rv;
    halt_req       = hr;
    deq_ready      = dr;
    startAddress   = sa;
    redirect_addr  = ra;
    e.cur       = m_pc;
    e.valid     = (mq.size() > 0);
    e.hpc       = e.valid ? mq[0].pc : 32'h0;
    e.hinst     = e.valid ? mq[0].inst : 32'h0;
    e.occ       = mq.size();
    e.halted    = (m_st == 2);
    e.zero_head = m_fresh;
`ifdef FETCH_PERF_EN
    e.pf  = 32'(m_pf);
    e.pfl = 32'(m_pfl);
`else
    e.pf  = 32'h0;
    e.pfl = 32'h0;
`endif
    sb.push_back(e);
    model_step(r, ps, rv, hr, dr, sa, ra);
  endtask

  task automatic idle(input int n, input logic dr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, dr, 0, 0);
  endtask

  // monitor
  initial begin
    exp_t e;
    logic bad;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        bad = 1'b0;
        n_vec++;
        if (currentAddress !== e.cur) begin
          $display("FAIL pc: got %h want %h", currentAddress, e.cur);
          bad = 1'b1;
        end
        if (inst_valid !== e.valid) begin
          $display("FAIL valid: got %b want %b", inst_valid, e.valid);
          bad = 1'b1;
        end
        if (int'(occupancy) != e.occ || $isunknown(occupancy)) begin
          $display("FAIL occ: got %0d want %0d", occupancy, e.occ);
          bad = 1'b1;
        end
        if (halted !== e.halted) begin
          $display("FAIL halted: got %b want %b", halted, e.halted);
          bad = 1'b1;
        end
        if ((e.valid || e.zero_head) &&
            (inst_pc !== e.hpc || inst_out !== e.hinst)) begin
          $display("FAIL head: got %h/%h want %h/%h",
                   inst_pc, inst_out, e.hpc, e.hinst);
          bad = 1'b1;
        end
        if (perf_fetched !== e.pf || perf_flushed !== e.pfl) begin
          $display("FAIL perf: got %0d/%0d want %0d/%0d",
                   perf_fetched, perf_flushed, e.pf, e.pfl);
          bad = 1'b1;
        end
        if (bad) n_err++;
      end
    end
  end

  initial begin
    int guard;
    reset = 1; pcSelector = 0; redirect_valid = 0; halt_req = 0;
    deq_ready = 0; startAddress = 0; redirect_addr = 0;
    model_reset();
    @(posedge clk);
    // boot
    step(1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 32'h1000, 0);
    step(0, 1, 0, 0, 1, 32'h1000, 0);
    idle(8, 1);
    // back-pressure
    idle(10, 0);
    idle(8, 1);
    // redirect with 3 queued
    guard = 0;
    while (mq.size() != 3 && guard < 20) begin
      step(0, 0, 0, 0, mq.size() > 3, 0, 0);
      guard++;
    end
    step(0, 0, 1, 0, 0, 0, 32'h2000);
    idle(4, 1);
    // halt, drain, resume via redirect
    step(0, 0, 0, 1, 0, 0, 0);
    idle(6, 1);
    step(0, 0, 1, 0, 1, 0, 32'h3000);
    idle(5, 1);
    // redirect together with halt
    step(0, 0, 1, 1, 1, 0, 32'h4000);
    idle(3, 1);
    step(0, 0, 1, 0, 1, 0, 32'h5000);
    // wrap
    step(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 0);
    idle(6, 1);
    // reset with full FIFO and redirect
    idle(6, 0);
    step(1, 0, 1, 0, 0, 0, 32'h6000);
    idle(4, 1);
    // random
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99) < 2,
           $urandom_range(99) < 4,
           $urandom_range(99) < 10,
           $urandom_range(99) < 6,
           $urandom_range(99) < 60,
           $urandom_range(3) == 0 ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC),
           $urandom & 32'hFFFF_FFFC);
    end
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #5;
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d pending want 0", sb.size());
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
